// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - decode-to-execute bus bundle for the ID/EX pipeline register
interface id_ex_stage_if #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
);
  logic               valid_d;
  logic               RegWrite_d;
  logic [1:0]         ResultSrc_d;
  logic               MemWrite_d;
  logic               Branch_d;
  logic               Jump_d;
  logic               ALUSrc_d;
  logic [1:0]         ALUOp_d;
  logic [RADDR_W-1:0] Rs1_d, Rs2_d, Rd_d;
  logic [XLEN-1:0]    RD1_d, RD2_d, PC_d, PCPlus4_d, ImmExt_d;
  logic               stall_e;
  logic               flush_e;

  logic               valid_e;
  logic               RegWrite_e;
  logic [1:0]         ResultSrc_e;
  logic               MemWrite_e;
  logic               Branch_e;
  logic               Jump_e;
  logic               ALUSrc_e;
  logic [1:0]         ALUOp_e;
  logic [RADDR_W-1:0] Rs1_e, Rs2_e, Rd_e;
  logic [XLEN-1:0]    RD1_e, RD2_e, PC_e, PCPlus4_e, ImmExt_e;
  logic               stall_d;
  logic [31:0]        bubble_cnt;

  modport slave (
    input  valid_d, RegWrite_d, ResultSrc_d, MemWrite_d, Branch_d, Jump_d, ALUSrc_d, ALUOp_d,
           Rs1_d, Rs2_d, Rd_d, RD1_d, RD2_d, PC_d, PCPlus4_d, ImmExt_d, stall_e, flush_e,
    output valid_e, RegWrite_e, ResultSrc_e, MemWrite_e, Branch_e, Jump_e, ALUSrc_e, ALUOp_e,
           Rs1_e, Rs2_e, Rd_e, RD1_e, RD2_e, PC_e, PCPlus4_e, ImmExt_e, stall_d, bubble_cnt
  );

  modport master (
    output valid_d, RegWrite_d, ResultSrc_d, MemWrite_d, Branch_d, Jump_d, ALUSrc_d, ALUOp_d,
           Rs1_d, Rs2_d, Rd_d, RD1_d, RD2_d, PC_d, PCPlus4_d, ImmExt_d, stall_e, flush_e,
    input  valid_e, RegWrite_e, ResultSrc_e, MemWrite_e, Branch_e, Jump_e, ALUSrc_e, ALUOp_e,
           Rs1_e, Rs2_e, Rd_e, RD1_e, RD2_e, PC_e, PCPlus4_e, ImmExt_e, stall_d, bubble_cnt
  );
endinterface

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use hazard detection
// Optional load-use bubble counter enabled by defining ID_EX_BUBBLE_CNT_EN.
module id_ex_stage #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic           clk,
  input  logic           reset,
  id_ex_stage_if.slave   bus
);
  typedef struct packed {
    logic               valid;
    logic               reg_write;
    logic [1:0]         result_src;
    logic               mem_write;
    logic               branch;
    logic               jump;
    logic               alu_src;
    logic [1:0]         alu_op;
    logic [RADDR_W-1:0] rs1;
    logic [RADDR_W-1:0] rs2;
    logic [RADDR_W-1:0] rd;
    logic [XLEN-1:0]    rd1;
    logic [XLEN-1:0]    rd2;
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    pc_plus4;
    logic [XLEN-1:0]    imm;
  } ex_t;

  ex_t  ex_q, ex_d, dec_load;
  logic lu;

  // State-committing controls are gated so an invalid slot can never write.
  always_comb begin
    dec_load            = '0;
    dec_load.valid      = bus.valid_d;
    dec_load.reg_write  = bus.RegWrite_d & bus.valid_d;
    dec_load.result_src = bus.ResultSrc_d;
    dec_load.mem_write  = bus.MemWrite_d & bus.valid_d;
    dec_load.branch     = bus.Branch_d & bus.valid_d;
    dec_load.jump       = bus.Jump_d & bus.valid_d;
    dec_load.alu_src    = bus.ALUSrc_d;
    dec_load.alu_op     = bus.ALUOp_d;
    dec_load.rs1        = bus.Rs1_d;
    dec_load.rs2        = bus.Rs2_d;
    dec_load.rd         = bus.Rd_d;
    dec_load.rd1        = bus.RD1_d;
    dec_load.rd2        = bus.RD2_d;
    dec_load.pc         = bus.PC_d;
    dec_load.pc_plus4   = bus.PCPlus4_d;
    dec_load.imm        = bus.ImmExt_d;
  end

  assign lu = ex_q.valid & ex_q.reg_write & (ex_q.result_src == 2'b01) &
              (ex_q.rd != '0) & bus.valid_d &
              ((ex_q.rd == bus.Rs1_d) | (ex_q.rd == bus.Rs2_d));

  assign bus.stall_d = bus.stall_e | (lu & ~bus.flush_e);

  always_comb begin
    ex_d = ex_q;
    if (!bus.stall_e) begin
      if (bus.flush_e || lu) ex_d = '0;
      else                   ex_d = dec_load;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ex_q <= '0;
    else       ex_q <= ex_d;
  end

  assign bus.valid_e     = ex_q.valid;
  assign bus.RegWrite_e  = ex_q.reg_write;
  assign bus.ResultSrc_e = ex_q.result_src;
  assign bus.MemWrite_e  = ex_q.mem_write;
  assign bus.Branch_e    = ex_q.branch;
  assign bus.Jump_e      = ex_q.jump;
  assign bus.ALUSrc_e    = ex_q.alu_src;
  assign bus.ALUOp_e     = ex_q.alu_op;
  assign bus.Rs1_e       = ex_q.rs1;
  assign bus.Rs2_e       = ex_q.rs2;
  assign bus.Rd_e        = ex_q.rd;
  assign bus.RD1_e       = ex_q.rd1;
  assign bus.RD2_e       = ex_q.rd2;
  assign bus.PC_e        = ex_q.pc;
  assign bus.PCPlus4_e   = ex_q.pc_plus4;
  assign bus.ImmExt_e    = ex_q.imm;

`ifdef ID_EX_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  // Only load-use bubbles count; flushes and downstream holds do not.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (!bus.stall_e && !bus.flush_e && lu && (bubble_cnt_q != 32'hFFFF_FFFF))
      bubble_cnt_d = bubble_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) bubble_cnt_q <= '0;
    else       bubble_cnt_q <= bubble_cnt_d;
  end

  assign bus.bubble_cnt = bubble_cnt_q;
`else
  assign bus.bubble_cnt = 32'h0;
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - self-checking bench for id_ex_stage with a behavioural EX-slot model
module tb_id_ex_stage;
  localparam int XLEN = 32;
  localparam int RW   = 5;

  typedef struct packed {
    logic          valid;
    logic          reg_write;
    logic [1:0]    result_src;
    logic          mem_write;
    logic          branch;
    logic          jump;
    logic          alu_src;
    logic [1:0]    alu_op;
    logic [RW-1:0] rs1, rs2, rd;
    logic [31:0]   rd1, rd2, pc, pc4, imm;
  } slot_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   done     = 0;

  slot_t       m     = '0;
  logic [31:0] m_cnt = '0;

  id_ex_stage_if #(.XLEN(XLEN), .RADDR_W(RW)) bus ();
  id_ex_stage #(.XLEN(XLEN), .RADDR_W(RW)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_lu();
    return m.valid && m.reg_write && (m.result_src == 2'b01) && (m.rd != 0) &&
           bus.valid_d && ((m.rd == bus.Rs1_d) || (m.rd == bus.Rs2_d));
  endfunction

  // Reference: what the EX slot must hold after each edge, from the priority rules.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m     = '0;
      m_cnt = '0;
    end else if (bus.stall_e) begin
      m = m;
    end else if (bus.flush_e) begin
      m = '0;
    end else if (model_lu()) begin
      m = '0;
`ifdef ID_EX_BUBBLE_CNT_EN
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
`endif
    end else begin
      m.valid      = bus.valid_d;
      m.reg_write  = bus.valid_d ? bus.RegWrite_d : 1'b0;
      m.mem_write  = bus.valid_d ? bus.MemWrite_d : 1'b0;
      m.branch     = bus.valid_d ? bus.Branch_d   : 1'b0;
      m.jump       = bus.valid_d ? bus.Jump_d     : 1'b0;
      m.result_src = bus.ResultSrc_d;
      m.alu_src    = bus.ALUSrc_d;
      m.alu_op     = bus.ALUOp_d;
      m.rs1 = bus.Rs1_d;  m.rs2 = bus.Rs2_d;  m.rd = bus.Rd_d;
      m.rd1 = bus.RD1_d;  m.rd2 = bus.RD2_d;
      m.pc  = bus.PC_d;   m.pc4 = bus.PCPlus4_d; m.imm = bus.ImmExt_d;
    end
  end

  always @(negedge clk) begin
    if (!done) begin
      slot_t d;
      d = {bus.valid_e, bus.RegWrite_e, bus.ResultSrc_e, bus.MemWrite_e, bus.Branch_e,
           bus.Jump_e, bus.ALUSrc_e, bus.ALUOp_e, bus.Rs1_e, bus.Rs2_e, bus.Rd_e,
           bus.RD1_e, bus.RD2_e, bus.PC_e, bus.PCPlus4_e, bus.ImmExt_e};
      check("ex_slot", 192'(d), 192'(m));
      check("stall_d", 192'(bus.stall_d),
            192'(bus.stall_e || (model_lu() && !bus.flush_e)));
      check("bubble_cnt", 192'(bus.bubble_cnt), 192'(m_cnt));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_dec(input logic v, input logic rw, input logic [1:0] rs, input logic br,
                         input logic [1:0] aop, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] rd, input logic [31:0] pc);
    bus.valid_d = v;  bus.RegWrite_d = rw; bus.ResultSrc_d = rs; bus.MemWrite_d = 1'b0;
    bus.Branch_d = br; bus.Jump_d = 1'b0;  bus.ALUSrc_d = 1'b0;  bus.ALUOp_d = aop;
    bus.Rs1_d = r1; bus.Rs2_d = r2; bus.Rd_d = rd;
    bus.RD1_d = $urandom; bus.RD2_d = $urandom; bus.ImmExt_d = $urandom;
    bus.PC_d = pc; bus.PCPlus4_d = pc + 32'd4;
  endtask

  task automatic rand_dec();
    bus.valid_d = ($urandom_range(0, 9) != 0);
    bus.RegWrite_d = $urandom; bus.ResultSrc_d = $urandom; bus.MemWrite_d = $urandom;
    bus.Branch_d = $urandom;   bus.Jump_d = $urandom;      bus.ALUSrc_d = $urandom;
    bus.ALUOp_d = $urandom;
    bus.Rs1_d = $urandom_range(0, 7); bus.Rs2_d = $urandom_range(0, 7);
    bus.Rd_d  = $urandom_range(0, 7);
    bus.RD1_d = $urandom; bus.RD2_d = $urandom; bus.ImmExt_d = $urandom;
    bus.PC_d = $urandom & 32'hFFFF_FFFC; bus.PCPlus4_d = bus.PC_d + 32'd4;
  endtask

  logic [31:0] exp_cnt;

  initial begin
    bus.stall_e = 0; bus.flush_e = 0;
    set_dec(0, 0, 2'b00, 0, 2'b00, 0, 0, 0, 32'h0);
    repeat (2) @(posedge clk);
    #2 reset = 0;

    // add x3,x1,x2 passes straight through
    set_dec(1, 1, 2'b00, 0, 2'b10, 5'd1, 5'd2, 5'd3, 32'h40);
    #1 check("pass_stall_d", 192'(bus.stall_d), 192'(0));
    step();
    check("pass_valid_e", 192'(bus.valid_e), 192'(1));
    check("pass_regwrite", 192'(bus.RegWrite_e), 192'(1));
    check("pass_aluop", 192'(bus.ALUOp_e), 192'(2'b10));
    check("pass_rd", 192'(bus.Rd_e), 192'(3));
    check("pass_pc4", 192'(bus.PCPlus4_e), 192'(32'h44));

    // asynchronous reset between edges
    #1 reset = 1;
    #1 check("areset_valid_e", 192'(bus.valid_e), 192'(0));
    check("areset_rd", 192'(bus.Rd_e), 192'(0));
    check("areset_pc", 192'(bus.PC_e), 192'(0));
    #2 reset = 0;
    step();

`ifdef ID_EX_BUBBLE_CNT_EN
    exp_cnt = 32'd1;
`else
    exp_cnt = 32'd0;
`endif

    // lw x5 then add x6,x5,x7
    set_dec(1, 1, 2'b01, 0, 2'b00, 5'd1, 5'd0, 5'd5, 32'h100);
    step();
    set_dec(1, 1, 2'b00, 0, 2'b10, 5'd5, 5'd7, 5'd6, 32'h104);
    #1 check("lu_stall_d", 192'(bus.stall_d), 192'(1));
    step();
    check("lu_bubble_valid", 192'(bus.valid_e), 192'(0));
    check("lu_bubble_rw", 192'(bus.RegWrite_e), 192'(0));
    check("lu_bubble_rs", 192'(bus.ResultSrc_e), 192'(0));
    check("lu_stall_gone", 192'(bus.stall_d), 192'(0));
    check("lu_cnt", 192'(bus.bubble_cnt), 192'(exp_cnt));
    step();
    check("lu_add_valid", 192'(bus.valid_e), 192'(1));
    check("lu_add_rd", 192'(bus.Rd_e), 192'(6));
    check("lu_add_rs1", 192'(bus.Rs1_e), 192'(5));

    // lw x0 never stalls
    set_dec(1, 1, 2'b01, 0, 2'b00, 5'd1, 5'd0, 5'd0, 32'h200);
    step();
    set_dec(1, 1, 2'b00, 0, 2'b10, 5'd0, 5'd0, 5'd8, 32'h204);
    #1 check("x0_stall_d", 192'(bus.stall_d), 192'(0));
    step();
    check("x0_no_bubble", 192'(bus.valid_e), 192'(1));

    // flush wins over load-use
    set_dec(1, 1, 2'b01, 0, 2'b00, 5'd1, 5'd0, 5'd5, 32'h300);
    step();
    set_dec(1, 1, 2'b00, 0, 2'b10, 5'd5, 5'd5, 5'd9, 32'h304);
    bus.flush_e = 1;
    #1 check("flush_stall_d", 192'(bus.stall_d), 192'(0));
    step();
    check("flush_valid_e", 192'(bus.valid_e), 192'(0));
    check("flush_cnt", 192'(bus.bubble_cnt), 192'(exp_cnt));
    bus.flush_e = 0;

    // stall holds a beq despite a pending flush
    set_dec(1, 0, 2'b00, 1, 2'b01, 5'd1, 5'd2, 5'd0, 32'h400);
    step();
    bus.stall_e = 1; bus.flush_e = 1;
    set_dec(1, 1, 2'b00, 0, 2'b10, 5'd3, 5'd4, 5'd10, 32'h404);
    for (int i = 0; i < 3; i++) begin
      #1 check("hold_stall_d", 192'(bus.stall_d), 192'(1));
      step();
      check("hold_branch", 192'(bus.Branch_e), 192'(1));
      check("hold_pc", 192'(bus.PC_e), 192'(32'h400));
    end
    bus.stall_e = 0;
    #1 check("unhold_stall_d", 192'(bus.stall_d), 192'(0));
    step();
    check("unhold_bubble", 192'(bus.valid_e), 192'(0));
    check("unhold_branch", 192'(bus.Branch_e), 192'(0));
    bus.flush_e = 0;

    // randomized traffic: decode holds while stall_d, flush persists through stalls
    begin
      bit hold, keep_flush;
      hold = 0; keep_flush = 0;
      for (int c = 0; c < 3000; c++) begin
        if (!hold) rand_dec();
        bus.stall_e = ($urandom_range(0, 4) == 0);
        bus.flush_e = keep_flush ? 1'b1 : ($urandom_range(0, 6) == 0);
        #1;
        hold = bus.stall_d;
        keep_flush = bus.stall_e && bus.flush_e;
        step();
      end
    end

    @(posedge clk);
    #1 done = 1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1);
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage RV32I core.
- Captures the main-decoder control fields plus decode-stage operands each cycle and presents them to EX.
- Contains the load-use hazard detector: it inserts a bubble into EX and tells IF/ID to hold.
- Honours a downstream hold (stall_e) and a branch/jump squash (flush_e).

Parameters:
XLEN, 32, datapath width for register operands, PC and immediate.
RADDR_W, 5, register-file address width.

Ports:
clk  input  1  core clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
valid_d  input  1  decode slot holds a real instruction
RegWrite_d  input  1  decoder control
ResultSrc_d  input  2  decoder control (01 = load result)
MemWrite_d  input  1  decoder control
Branch_d  input  1  decoder control
Jump_d  input  1  decoder control
ALUSrc_d  input  1  decoder control
ALUOp_d  input  2  decoder control
Rs1_d, Rs2_d, Rd_d  input  RADDR_W each  register specifiers from instruction
RD1_d, RD2_d  input  XLEN each  register-file read data
PC_d, PCPlus4_d, ImmExt_d  input  XLEN each  decode-stage PC, PC+4, extended immediate
stall_e  input  1  EX/MEM cannot advance; hold this register
flush_e  input  1  taken branch/jump resolved in EX; squash the instruction entering EX
valid_e  output  1  EX slot holds a real instruction
RegWrite_e, ResultSrc_e, MemWrite_e, Branch_e, Jump_e, ALUSrc_e, ALUOp_e  output  widths as _d  registered controls
Rs1_e, Rs2_e, Rd_e, RD1_e, RD2_e, PC_e, PCPlus4_e, ImmExt_e  output  widths as _d  registered operands
stall_d  output  1  combinational; IF/ID must hold its contents this cycle
bubble_cnt  output  32  load-use bubble count (see Optional Feature)

Behaviour:
- Reset (async, immediate):
  - all _e outputs and valid_e go to 0.
  - bubble_cnt goes to 0.
- Load-use hazard (combinational):
  - lu = valid_e & RegWrite_e & (ResultSrc_e==2'b01) & (Rd_e!=0) & valid_d & ((Rd_e==Rs1_d) | (Rd_e==Rs2_d)).
  - The check is conservative: Rs fields are compared even for formats that do not read them.
  - A false stall is legal.
- stall_d = stall_e | (lu & ~flush_e).
- Next-state priority on each clock edge, highest first:
  1. stall_e=1: hold every register, including valid_e; flush_e and lu are ignored that cycle. The flush source keeps flush_e asserted until stall_e drops.
  2. flush_e=1: load a bubble. No lu bubble is counted.
  3. lu=1: load a bubble. The held decode instruction re-enters next cycle.
  4. Otherwise: load all _d fields; valid_e = valid_d.
- Bubble definition:
  - valid_e = 0.
  - RegWrite_e, MemWrite_e, Branch_e and Jump_e = 0.
  - All other _e fields = 0.
- valid_d=0 with a normal load:
  - controls and valid_e load as given by the normal load.
  - RegWrite_e, MemWrite_e, Branch_e and Jump_e are forced to 0, so EX never commits state from an invalid slot.
- Latency: one cycle from _d to _e. stall_d has zero cycles of latency (combinational).
- A load-use stall lasts exactly one cycle:
  - After the bubble, valid_e=0, so lu deasserts.
  - Forwarding from MEM/WB then covers the dependency.
- Rd_e=x0 never triggers a stall.

Optional Feature:
- Macro: ID_EX_BUBBLE_CNT_EN.
- Defined:
  - bubble_cnt increments by 1 on each edge where a bubble is loaded because of lu (priority 3 only).
  - The counter saturates at 32'hFFFF_FFFF.
  - It is cleared only by reset.
- Not defined:
  - no counter flops are built.
  - bubble_cnt is tied to 32'h0.

Test Plan:
- Reset mid-stream: assert reset asynchronously between edges with valid_e=1 -> all _e outputs and valid_e are 0 immediately, before the next clk edge.
- Plain pass-through: add x3,x1,x2 decoded (RegWrite_d=1, ALUOp_d=10, Rd_d=3), no hazards -> next cycle _e fields equal the inputs, valid_e=1, stall_d=0.
- Load-use: lw x5 in EX (ResultSrc_e=01, Rd_e=5); decode add x6,x5,x7 -> stall_d=1 for one cycle, next edge valid_e=0 with all controls 0, add enters EX the following cycle, bubble_cnt=1 (macro on) or 0 (macro off).
- x0 destination: lw x0 in EX; decode reads x0 -> stall_d=0, no bubble.
- Flush beats load-use: flush_e=1 and lu=1 in the same cycle -> stall_d=0, bubble loaded, bubble_cnt unchanged.
- Stall beats flush: stall_e=1 and flush_e=1 for 3 cycles with beq in EX -> all _e outputs unchanged for 3 edges, stall_d=1; when stall_e drops with flush_e=1 -> bubble loaded.
